// File: rtl/outport_display_scanner_if.sv
// Bundle between the CPU Outport register and the seven-segment display scanner.
// The master modport drives the load strobe, data and hold.
// The slave modport (the scanner) drives the display and status outputs.
interface outport_display_scanner_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DIGITS = 8
);
  logic                  outport_in_i;    // load strobe
  logic [DATA_WIDTH-1:0] outport_data_i;  // value to display
  logic                  hold_i;          // freeze shown value at frame boundaries
  logic [6:0]            seg_o;           // {g,f,e,d,c,b,a}, active-low
  logic [NUM_DIGITS-1:0] an_o;            // digit enables, active-low
  logic                  frame_done_o;    // pulse on the last cycle of a frame
  logic                  pending_o;       // shadow holds an uncommitted value
  logic [DATA_WIDTH-1:0] shown_value_o;   // value currently scanned

  modport master (
    output outport_in_i, outport_data_i, hold_i,
    input  seg_o, an_o, frame_done_o, pending_o, shown_value_o
  );

  modport slave (
    input  outport_in_i, outport_data_i, hold_i,
    output seg_o, an_o, frame_done_o, pending_o, shown_value_o
  );
endinterface

// File: rtl/outport_display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner for the CPU Outport.
// Loads land in a shadow register.
// The shadow is committed to the scanned value only at frame boundaries, so no frame shows a torn value.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank digits above the
// most-significant nonzero nibble. Digit 0 always shows, so a value of 0 reads as '0'.
module outport_display_scanner #(
  parameter int DATA_WIDTH  = 32,     // must equal 4*NUM_DIGITS
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000   // cycles each digit stays lit, >= 2
) (
  input logic                      clk,
  input logic                      rst,
  outport_display_scanner_if.slave bus
);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, SCAN} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] shown_q, shown_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  boundary;
  logic                  digit_blank;
  logic [3:0]            nib [NUM_DIGITS];

  // Active-low gfedcba glyphs for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Split the scanned value into per-digit nibbles
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib[gi] = shown_q[4*gi +: 4];
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd;
  // Index of the most-significant nonzero nibble (0 when the value is 0)
  always_comb begin
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (nib[i] != 4'h0) msd = IDX_W'(i);
    end
  end
  assign digit_blank = (idx_q > msd);
`else
  assign digit_blank = 1'b0;
`endif

  // Last cycle of the last digit: the idx wrap happens on the closing edge
  assign boundary = (state_q == SCAN) && (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);

  // State and datapath registers; reset may arrive at any time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      shown_q   <= '0;
      pending_q <= 1'b0;
      seg_q     <= 7'h7F;
      an_q      <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      shown_q   <= shown_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  // Next-state: scan counters, shadow loads, frame-boundary commit, display drive
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    shown_d   = shown_q;
    pending_d = pending_q;
    seg_d     = 7'h7F;
    an_d      = '1;

    case (state_q)
      BLANK: begin
        // First load is shown right away; counters are already 0
        if (bus.outport_in_i) begin
          state_d  = SCAN;
          shown_d  = bus.outport_data_i;
          shadow_d = bus.outport_data_i;
        end
      end
      default: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Commit reads the pre-load shadow; a coincident load then re-arms pending
        if (boundary && pending_q && !bus.hold_i) begin
          shown_d   = shadow_q;
          pending_d = 1'b0;
        end
        if (bus.outport_in_i) begin
          shadow_d  = bus.outport_data_i;
          pending_d = 1'b1;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
          an_d[i] = (idx_q != IDX_W'(i));
        end
        seg_d = digit_blank ? 7'h7F : hex7(nib[idx_q]);
      end
    endcase
  end

  assign bus.seg_o         = seg_q;
  assign bus.an_o          = an_q;
  assign bus.frame_done_o  = boundary;
  assign bus.pending_o     = pending_q;
  assign bus.shown_value_o = shown_q;
endmodule
